// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3) driving a 4-digit display bus.
// Result registers update only at the end of a conversion; inputs above 9999 saturate.
module bin_to_bcd #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd,
  output logic             overflow
);

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
  localparam int unsigned MAX_DEC = 9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   adj;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic; add-3 is per nibble with no inter-nibble carry
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    adj = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = bin;
          scratch_d  = '0;
          cnt_d      = CNT_W'(WIDTH);
          ovf_pend_d = (32'(bin) > MAX_DEC);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], sr_q[WIDTH-1]};
        sr_d      = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = ovf_pend_q ? 16'h9999 : scratch_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed self-checking bench for bin_to_bcd (WIDTH=14).
module tb_bin_to_bcd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [15:0] last_bcd;

  bin_to_bcd #(.WIDTH(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int v);
    int m;
    m = (v > 9999) ? 9999 : v;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Called #1 after an edge. Accept happens at the next edge (E0); a nonzero
  // poke drives start=1 with bin=1111 into edge E<poke>, which must be ignored.
  task automatic conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                      input int poke);
    bin   = 14'(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 14'(v) ^ 14'h2AAA;
    chk("busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      if (poke != 0 && k == poke) begin
        start = 1'b1;
        bin   = 14'd1111;
      end
      @(posedge clk); #1;
      if (poke != 0 && k == poke) start = 1'b0;
      if (k == 7 || k == 14) begin
        chk("busy_mid", 32'(busy), 32'd1);
        chk("done_mid", 32'(done), 32'd0);
        chk("bcd_hold", 32'(bcd), 32'(last_bcd));
      end
    end
    chk("done_e15", 32'(done), 32'd1);
    chk("busy_e15", 32'(busy), 32'd0);
    chk("bcd", 32'(bcd), 32'(exp_bcd));
    chk("ovf", 32'(overflow), 32'(exp_ovf));
    @(posedge clk); #1;
    chk("done_clr", 32'(done), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("bcd_after", 32'(bcd), 32'(exp_bcd));
    last_bcd = exp_bcd;
  endtask

  initial begin
    int vals[$];
    int ndone;
    int prev;
    bit found;

    rst_n    = 1'b0;
    start    = 1'b0;
    bin      = '0;
    last_bcd = 16'h0000;

    // Reset values, during and after reset
    @(posedge clk); #1;
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_bcd", 32'(bcd), 32'h0);
    chk("idle_ovf", 32'(overflow), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    conv(1234,  16'h1234, 1'b0, 0);
    conv(0,     16'h0000, 1'b0, 0);
    conv(9,     16'h0009, 1'b0, 3);
    conv(9999,  16'h9999, 1'b0, 0);
    conv(10000, 16'h9999, 1'b1, 0);
    conv(16383, 16'h9999, 1'b1, 0);
    conv(42,    16'h0042, 1'b0, 0);

    // Abort: start ignored at E3, reset before E8 drops everything
    bin   = 14'd5678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 14'd1111;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_nodone", 32'(ndone), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    last_bcd = 16'h0000;
    conv(5678, 16'h5678, 1'b0, 0);

    // Back-to-back conversions with start held high
    for (int v = 0; v < 300; v++) vals.push_back(v);
    for (int v = 9990; v <= 10005; v++) vals.push_back(v);
    for (int v = 16380; v <= 16383; v++) vals.push_back(v);
    bin   = 14'(vals[0]);
    start = 1'b1;
    prev  = 0;
    for (int i = 0; i < vals.size(); i++) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        @(posedge clk); #1;
        if (done) found = 1'b1;
      end
      if (!found) begin
        chk("sweep_timeout", 32'd0, 32'd1);
        break;
      end
      chk("sweep_bcd", 32'(bcd), 32'(model(vals[i])));
      chk("sweep_ovf", 32'(overflow), (vals[i] > 9999) ? 32'd1 : 32'd0);
      if (i > 0) chk("sweep_gap", 32'(cyc - prev), 32'd16);
      prev = cyc;
      if (i + 1 < vals.size()) bin = 14'(vals[i + 1]);
      else start = 1'b0;
    end
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("sweep_tail_nodone", 32'(ndone), 32'd0);
    chk("sweep_tail_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
